// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S/left-justified stereo serializer; in: audio_mclk, reset_n, s_valid, s_l, s_r, mute; out: s_ready, audio_sclk, audio_lrck, audio_dac, frame_start, underrun
module audio_i2s_tx #(
  parameter int DW = 16,
  parameter int I2S_MODE = 1,
  parameter int MCLK_DIV = 4,
  parameter int SLOT_BITS = 32
) (
  input  logic          audio_mclk,
  input  logic          reset_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_l,
  input  logic [DW-1:0] s_r,
  input  logic          mute,
  output logic          audio_sclk,
  output logic          audio_lrck,
  output logic          audio_dac,
  output logic          frame_start,
  output logic          underrun
);
  localparam int FB = 2 * SLOT_BITS;
  localparam int BW = $clog2(FB);
  localparam int VW = $clog2(MCLK_DIV);
  logic [VW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt, k, j;
  logic tick, load, bypass, xfer, hold_full, lrck_nxt, dac_nxt;
  logic [DW-1:0] hold_l, hold_r, last_l, last_r, cur_l, cur_r, new_l, new_r, word, sh;
  assign s_ready = !hold_full;
  assign tick = div_cnt == VW'(MCLK_DIV - 1);
  assign div_nxt = tick ? '0 : div_cnt + 1'b1;
  assign bit_nxt = bit_cnt == BW'(FB - 1) ? '0 : bit_cnt + 1'b1;
  assign load = tick && bit_cnt == BW'(FB - 1);
  assign bypass = load && !mute && !hold_full && s_valid;
  assign xfer = s_valid && !hold_full && !bypass;
  assign new_l = mute ? '0 : hold_full ? hold_l : s_valid ? s_l : last_l;
  assign new_r = mute ? '0 : hold_full ? hold_r : s_valid ? s_r : last_r;
  assign lrck_nxt = bit_nxt >= BW'(SLOT_BITS);
  // a load always lands on bit 0 (left slot), so the right word never needs the bypass path
  assign word = lrck_nxt ? cur_r : load ? new_l : cur_l;
  assign k = lrck_nxt ? bit_nxt - BW'(SLOT_BITS) : bit_nxt;
  // j wraps high when k < I2S_MODE, which puts it outside the data window
  assign j = k - BW'(I2S_MODE);
  assign sh = word >> (BW'(DW - 1) - j);
  assign dac_nxt = j < BW'(DW) && sh[0];
  always_ff @(posedge audio_mclk or negedge reset_n)
    if (!reset_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      hold_full <= 1'b0;
      hold_l <= '0;
      hold_r <= '0;
      last_l <= '0;
      last_r <= '0;
      cur_l <= '0;
      cur_r <= '0;
      audio_sclk <= 1'b0;
      audio_lrck <= 1'b0;
      audio_dac <= 1'b0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      audio_sclk <= div_nxt >= VW'(MCLK_DIV / 2);
      frame_start <= load;
      underrun <= load && !mute && !hold_full && !s_valid;
      hold_full <= xfer ? 1'b1 : load ? 1'b0 : hold_full;
      if (xfer) begin
        hold_l <= s_l;
        hold_r <= s_r;
      end
      if (tick) begin
        bit_cnt <= bit_nxt;
        audio_lrck <= lrck_nxt;
        audio_dac <= dac_nxt;
      end
      if (load) begin
        cur_l <= new_l;
        cur_r <= new_r;
      end
      if (load && !mute) begin
        last_l <= new_l;
        last_r <= new_r;
      end
    end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: randomized and directed check of audio_i2s_tx (I2S and left-justified) against a frame-level model
module tb_audio_i2s_tx;
  localparam int D = 4;
  localparam int FRAME = D * 64;
  logic clk = 1'b0, reset_n = 1'b0, s_valid = 1'b0, mute = 1'b0;
  logic [15:0] s_l = '0, s_r = '0;
  logic rdy0, sclk0, lrck0, dac0, fs0, ur0;
  logic rdy1, sclk1, lrck1, dac1, fs1, ur1;
  int n_chk = 0, n_fail = 0;
  int n = 0;
  logic qf = 1'b0, took = 1'b0, e_ur = 1'b0, e_fs = 1'b0, byp = 1'b0, rdy_m = 1'b1;
  logic [15:0] ql = '0, qr = '0, fl = '0, fr = '0, ll = '0, lr = '0;
  logic [63:0] c0, c1, cl;
  int cnt_ur, cnt_fs, cyc;
  logic [7:0] sp;
  logic [15:0] dat;
  always #5 clk = ~clk;
  audio_i2s_tx dut (
    .audio_mclk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(rdy0), .s_l(s_l), .s_r(s_r),
    .mute(mute), .audio_sclk(sclk0), .audio_lrck(lrck0), .audio_dac(dac0), .frame_start(fs0), .underrun(ur0)
  );
  audio_i2s_tx #(.I2S_MODE(0)) dut_lj (
    .audio_mclk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(rdy1), .s_l(s_l), .s_r(s_r),
    .mute(mute), .audio_sclk(sclk1), .audio_lrck(lrck1), .audio_dac(dac1), .frame_start(fs1), .underrun(ur1)
  );
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, a, e, $time);
    end
  endtask
  function automatic logic edac(input int off, input int b, input logic [15:0] l, input logic [15:0] r);
    int k;
    logic [15:0] w;
    k = b % 32;
    w = b >= 32 ? r : l;
    return (k >= off && k < off + 16) ? w[15 - (k - off)] : 1'b0;
  endfunction
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      n = 0; qf = 0; ql = 0; qr = 0; fl = 0; fr = 0; ll = 0; lr = 0;
      took = 0; e_ur = 0; e_fs = 0;
    end else begin
      n++;
      took = 0; byp = 0; e_ur = 0;
      rdy_m = !qf;
      e_fs = n % FRAME == 0;
      if (e_fs) begin
        if (mute) begin
          fl = 0; fr = 0; qf = 0;
        end else if (qf) begin
          fl = ql; fr = qr; ll = ql; lr = qr; qf = 0;
        end else if (s_valid) begin
          fl = s_l; fr = s_r; ll = s_l; lr = s_r; byp = 1; took = 1;
        end else begin
          fl = ll; fr = lr; e_ur = 1;
        end
      end
      if (s_valid && rdy_m && !byp) begin
        qf = 1; ql = s_l; qr = s_r; took = 1;
      end
    end
  always @(negedge clk) begin
    int b;
    b = (n / D) % 64;
    chk("sclk", sclk0, (n % D) >= D / 2);
    chk("sclk_lj", sclk1, (n % D) >= D / 2);
    chk("lrck", lrck0, b >= 32);
    chk("lrck_lj", lrck1, b >= 32);
    chk("dac_i2s", dac0, edac(1, b, fl, fr));
    chk("dac_lj", dac1, edac(0, b, fl, fr));
    chk("frame_start", {fs0, fs1}, {2{e_fs}});
    chk("underrun", {ur0, ur1}, {2{e_ur}});
    chk("s_ready", {rdy0, rdy1}, {2{!qf}});
  end
  task automatic wait_fs(input string nm);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (fs0) return;
    end
    chk({nm, "_timeout"}, 0, 1);
  endtask
  task automatic wait_phase(input int p);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (n % FRAME == p) return;
    end
    chk("phase_timeout", 0, 1);
  endtask
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    s_valid = 1; s_l = l; s_r = r;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (took) begin
        s_valid = 0;
        return;
      end
    end
    s_valid = 0;
    chk("send_timeout", 0, 1);
  endtask
  task automatic cap(output logic [63:0] a, output logic [63:0] b, output logic [63:0] l);
    a = 0; b = 0; l = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      a = {a[62:0], dac0}; b = {b[62:0], dac1}; l = {l[62:0], lrck0};
      if (i < 63) repeat (4) @(negedge clk);
    end
  endtask
  initial begin
    repeat (10) @(negedge clk);
    chk("rst_ready", rdy0, 1);
    chk("rst_outs", {sclk0, lrck0, dac0, fs0, ur0}, 0);
    reset_n = 1;
    cyc = 0;
    while (cyc < 600 && !fs0) begin
      @(negedge clk);
      cyc++;
    end
    chk("first_fs_cycle", cyc, 256);
    chk("first_ur", ur0, 1);
    send(16'hA5C3, 16'h0001);
    wait_fs("basic");
    sp = 0;
    cap(c0, c1, cl);
    chk("i2s_left", c0[63:32], 32'h52E18000);
    chk("i2s_right", c0[31:0], 32'h00008000);
    chk("lj_left", c1[63:32], 32'hA5C30000);
    chk("lj_right", c1[31:0], 32'h00010000);
    chk("lrck_frame", cl, 64'h00000000FFFFFFFF);
    wait_fs("sclk");
    for (int i = 0; i < 8; i++) begin
      sp = {sp[6:0], sclk0};
      @(negedge clk);
    end
    chk("sclk_pattern", sp, 8'h33);
    wait_phase(10);
    send(16'h1234, 16'h5678);
    cnt_ur = 0; cnt_fs = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      cnt_ur += ur0; cnt_fs += fs0;
    end
    chk("ur_count", cnt_ur, 2);
    chk("ur_frames", cnt_fs, 3);
    wait_fs("repeat");
    chk("repeat_ur", ur0, 1);
    cap(c0, c1, cl);
    chk("repeat_left", c0[63:32], 32'h091A0000);
    chk("repeat_right", c0[31:0], 32'h2B3C0000);
    cnt_ur = 0; cnt_fs = 0; dat = 16'h0100;
    repeat (4 * FRAME) begin
      if (!s_valid || took) begin
        s_valid = 1; s_l = dat; s_r = ~dat; dat++;
      end
      @(negedge clk);
      cnt_ur += ur0; cnt_fs += fs0;
    end
    for (int i = 0; i < 600 && !took; i++) @(negedge clk);
    s_valid = 0;
    chk("bp_underruns", cnt_ur, 0);
    chk("bp_frames", cnt_fs, 4);
    wait_phase(20);
    send(16'hDEAD, 16'hDEAD);
    wait_phase(FRAME - 1);
    mute = 1;
    @(negedge clk);
    mute = 0;
    chk("mute_fs", fs0, 1);
    chk("mute_clears_hold", rdy0, 1);
    chk("mute_no_ur", ur0, 0);
    cap(c0, c1, cl);
    chk("mute_data", c0, 0);
    wait_phase(FRAME - 1);
    s_valid = 1; s_l = 16'hBEEF; s_r = 16'h0F0F;
    @(negedge clk);
    s_valid = 0;
    chk("byp_fs", fs0, 1);
    chk("byp_no_ur", ur0, 0);
    chk("byp_ready", rdy0, 1);
    cap(c0, c1, cl);
    chk("byp_left", c0[63:32], 32'h5F778000);
    chk("byp_right", c0[31:0], 32'h07878000);
    repeat (37) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 0;
    repeat (3) @(negedge clk);
    chk("midrst_outs", {sclk0, lrck0, dac0, fs0, ur0, rdy0}, 6'b000001);
    reset_n = 1;
    cyc = 0;
    while (cyc < 600 && !fs0) begin
      @(negedge clk);
      cyc++;
    end
    chk("midrst_fs_cycle", cyc, 256);
    chk("midrst_ur", ur0, 1);
    repeat (30 * FRAME) begin
      mute = $urandom_range(0, 9) == 0;
      if (!s_valid || took) begin
        s_valid = $urandom_range(0, 199) == 0;
        s_l = 16'($urandom);
        s_r = 16'($urandom);
      end
      @(negedge clk);
    end
    s_valid = 0; mute = 0;
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- I2S serializer for the Pocket audio path. Sits directly downstream of the audio filter/attenuation stage and runs in the audio_mclk domain (12.288 MHz).
- Accepts stereo samples over a valid/ready handshake and double-buffers them against a free-running frame timer.
- Generates SCLK, LRCK and serial data for the Pocket DAC.
- Reports underruns when no new sample arrives in time for a frame.

Parameters:
- DW, 16: sample width; requires DW <= SLOT_BITS-1.
- I2S_MODE, 1: 1 = Philips I2S (MSB one SCLK after the LRCK edge); 0 = left-justified.
- MCLK_DIV, 4: audio_mclk cycles per SCLK period; even, >= 2.
- SLOT_BITS, 32: SCLK periods per channel slot. With the defaults, a frame is 256 MCLK cycles (48 kHz).

Ports:
- audio_mclk  in  1  block clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  sample pair offered.
- s_ready  out  1  block can accept a sample pair.
- s_l  in  DW  left sample, two's complement.
- s_r  in  DW  right sample, two's complement.
- mute  in  1  transmit zeros; sampled at the frame boundary.
- audio_sclk  out  1  serial bit clock.
- audio_lrck  out  1  0 = left slot, 1 = right slot.
- audio_dac  out  1  serial data, MSB first.
- frame_start  out  1  one-cycle pulse when a new frame loads.
- underrun  out  1  one-cycle pulse when a frame loaded without a fresh sample.

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - div_cnt = 0, bit_cnt = 0, shift register = 0, hold_full = 0, last_l = last_r = 0.
  - audio_sclk, audio_lrck, audio_dac, frame_start and underrun are all 0.
  - s_ready = 1, since it is combinational !hold_full.
  - Deassertion mid-frame restarts timing at bit_cnt = 0; any partially sent frame is discarded.
- Clock divider:
  - div_cnt counts 0..MCLK_DIV-1 and wraps.
  - audio_sclk is registered: 1 when div_cnt >= MCLK_DIV/2, else 0.
  - A "fall tick" is the cycle where div_cnt wraps to 0. All data, LRCK and bit_cnt updates occur only on fall ticks, so the receiver samples on the SCLK rising edge.
- Bit counter:
  - bit_cnt counts 0..2*SLOT_BITS-1 on fall ticks and wraps.
  - audio_lrck = (bit_cnt >= SLOT_BITS).
- Frame load: happens on the fall tick where bit_cnt wraps to 0, and pulses frame_start. The loaded source is, in priority order:
  1. mute = 1: load zeros. hold_full is still cleared if set (the sample is consumed and dropped).
  2. hold_full = 1: load {hold_l, hold_r}, clear hold_full, update last_l/last_r.
  3. hold empty, but s_valid = 1 the same cycle: bypass. Load s_l/s_r directly, assert s_ready (already 1), do not set hold_full. Not an underrun.
  4. Otherwise: load last_l/last_r (repeat the previous sample) and pulse underrun.
- Handshake:
  - A transfer occurs when s_valid & s_ready, outside case 3; it sets hold_full and captures hold_l/hold_r.
  - s_valid high while hold_full = 1 stalls; the data must be held stable by the source.
  - Maximum throughput is one pair per frame.
- Slot formatting (per channel):
  - Slot bit index k = bit_cnt mod SLOT_BITS; off = I2S_MODE.
  - audio_dac = sample[DW-1-(k-off)] for off <= k < off+DW, else 0.
  - In I2S mode, slot bit 0 carries zero padding. This is exactly the final LSB of the previous slot's zero padding, valid since DW <= SLOT_BITS-1.
  - Left slot uses the left word, right slot uses the right word.
  - audio_dac is registered, updated on fall ticks, in phase with audio_lrck.
- Latency: a pair accepted at least one cycle before a frame boundary has its left MSB on audio_dac at fall tick bit_cnt = off of that frame.
- Simultaneous events: mute asserted at the frame boundary overrides all sources. Underrun and frame_start pulse in the same cycle.
- No FSM beyond the counters; the block is always running after reset.

Test Plan:
- Reset: hold reset_n = 0 for 10 cycles, then release -> all outputs 0 during reset, s_ready = 1; the first frame_start occurs after 256 cycles with underrun = 1 and all-zero data.
- Basic I2S: offer L = 16'hA5C3, R = 16'h0001 once; capture 64 SCLK bits -> left slot reads 0, A5C3, then 15 zeros; right slot reads 0, 0001, then 15 zeros; LRCK low for 32 bits, high for 32; SCLK period = 4 MCLK.
- Left-justified (I2S_MODE = 0): same data -> MSB of A5C3 appears at slot bit 0, with 16 zero bits after it.
- Back-pressure: hold s_valid = 1 continuously with incrementing data -> one transfer per 256 cycles, s_ready low between frame loads, no underrun, consecutive frames carry consecutive values.
- Underrun: send 16'h1234/16'h5678, then stop -> the next frames repeat 1234/5678 and underrun pulses once per frame.
- Mute and bypass: set mute = 1 with hold_full -> zeros are sent and hold_full clears. Present s_valid exactly on the boundary cycle with the hold empty -> that sample is sent in this frame with no underrun.
